vga_tile_renderer: RTL and testbench
====================================

VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 SHALL have parameter TILE_LOG2, default 4, giving tile edge of 2^TILE_LOG2 pixels.
REQ-002 SHALL have parameter COLS, default 40, giving tile columns.
REQ-003 SHALL have parameter ROWS, default 30, giving tile rows.
REQ-004 SHALL have parameter CW, default 2, giving bits per tile code and a palette of 2^CW entries.
REQ-005 SHALL have parameter X0, default 0, giving the grid left origin in active pixels.
REQ-006 SHALL have parameter Y0, default 0, giving the grid top origin in active lines.
REQ-007 SHALL have parameter GAP, default 1, enabling a black one-pixel tile outline.
REQ-008 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-009 SHALL have port clrn, input, 1 bit: reset, synchronous, active-low.
REQ-010 SHALL have port pix_en, input, 1 bit: pixel-advance enable, one pixel per clk with pix_en=1.
REQ-011 SHALL have port tiles, input, ROWS*COLS*CW bits: tile n=row*COLS+col at bits [n*CW +: CW].
REQ-012 SHALL have port pal_we, input, 1 bit: palette write strobe.
REQ-013 SHALL have port pal_addr, input, CW bits: palette write index.
REQ-014 SHALL have port pal_data, input, 12 bits: colour as bbbb_gggg_rrrr.
REQ-015 SHALL have ports r, g and b, output, 4 bits each: colour out.
REQ-016 SHALL have ports hs and vs, output, 1 bit each: syncs, active-low.
REQ-017 SHALL have port frame_start, output, 1 bit: one-clk pulse at each frame wrap.

Function
REQ-018 SHALL keep h_count 0-799 and v_count 0-524, advancing only on clk with pix_en=1.
REQ-019 SHALL wrap h_count 799->0 and increment v_count on that wrap, with v_count wrapping 524->0.
REQ-020 SHALL hold every counter, pipeline register and output unchanged while pix_en=0.
REQ-021 SHALL decode timing as: active = h 143-782 and v 35-514; x = h-143; y = v-35; hs_raw = (h>95); vs_raw = (v>1).
REQ-022 SHALL take the grid pixel offset as (x-X0, y-Y0), and treat it as inside only if 0 <= x-X0 < COLS<<TILE_LOG2 and 0 <= y-Y0 < ROWS<<TILE_LOG2.
REQ-023 SHALL derive tile column/row as offset>>TILE_LOG2, and sub-pixel position as offset[TILE_LOG2-1:0].
REQ-024 SHALL resolve each pixel colour in priority order: not active -> 12'h000; outside grid -> palette[0]; GAP=1 and code!=0 and sub-pixel x or y equal to 0 or 2^TILE_LOG2-1 -> 12'h000; otherwise palette[code].
REQ-025 SHALL use pipeline stage 1 for tile/sub-pixel decode and snapshot read.
REQ-026 SHALL use pipeline stage 2 for palette lookup and registered r/g/b/hs/vs.
REQ-027 SHALL make r/g/b and hs/vs correspond to the counter value of exactly 2 enabled cycles earlier, so that syncs and colour remain aligned.
REQ-028 SHALL map colour to outputs as r=colour[3:0], g=colour[7:4], b=colour[11:8].
REQ-029 SHALL capture tiles into an internal snapshot only on the enabled cycle where h_count=0 and v_count=515, i.e. vblank start.
REQ-030 SHALL render each displayed frame solely from the snapshot, with no tearing from mid-frame changes to tiles.
REQ-031 SHALL write pal_data to palette[pal_addr] on any clk with pal_we=1, independent of pix_en.
REQ-032 SHALL have a palette write visible to stage 2 from the next clk.
REQ-033 SHALL, on a palette write to the same index as the current lookup, have that lookup return the old value.
REQ-034 SHALL pulse frame_start high for exactly one clk on the enabled cycle where the counters move from (799,524) to (0,0).
REQ-035 SHALL accept any ROWS*COLS, with unused counter range beyond the grid treated as outside.

Reset
REQ-036 SHALL, on clk with clrn=0, set h_count=0, v_count=0, snapshot=0, r=g=b=0, hs=0, vs=0 and frame_start=0.
REQ-037 SHALL, on reset, load the palette as [0]=12'h000, [1]=12'hF00, [2]=12'h0F0, [3]=12'h00F, with all other entries =12'h000.
REQ-038 SHALL give reset priority over pix_en and pal_we.
REQ-039 SHALL treat reset mid-frame as restarting timing at (0,0) on the first enabled cycle after release.

Verification
REQ-040 SHALL check default parameters with pix_en=1 continuously: hs low for 96 enabled cycles per 800, vs low for 2 lines per 525, and frame_start period 420000 clk.
REQ-041 SHALL check tile 0 code 1 with GAP=1: pixel (1,1) -> r=0,g=0,b=F after 2 cycles, and pixel (0,0) and pixel (15,3) -> 000.
REQ-042 SHALL check a tiles change at v=200: the current frame is unchanged, and the new content appears from the frame after v=515.
REQ-043 SHALL check pal_we writing [1]=12'h5FF during active video: pixels with code 1 show r=F,g=F,b=5 from the next clk.
REQ-044 SHALL check pix_en toggling 1:3 duty: outputs are identical to the continuous-run trace sampled on enabled cycles.
REQ-045 SHALL check clrn=0 held 3 clk at h=400,v=300: all outputs 0, the default palette is restored, and the first frame_start occurs 420000 enabled cycles after release.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer
//   Tile-grid VGA renderer. Free-running 800x525 pixel timing (advanced by
//   pix_en) drives a two-stage pipeline. Stage 1 decodes the counter position
//   into a tile code from a per-frame snapshot of the tile map. Stage 2 looks
//   up the colour in a writable palette and registers colour and syncs together.
//
// Ports
//   clk          single clock, rising edge
//   clrn         synchronous active-low reset
//   pix_en       advance one pixel on this clk
//   tiles        tile map, tile n = row*COLS+col at [n*CW +: CW]
//   pal_we       palette write strobe (independent of pix_en)
//   pal_addr     palette write index
//   pal_data     palette colour, bbbb_gggg_rrrr
//   r, g, b      registered colour out
//   hs, vs       registered active-low syncs, aligned with colour
//   frame_start  one-clk pulse when the counters wrap to (0,0)
//
// The H_*/V_* parameters describe the raster timing; their defaults give the
// 800x525 frame with active area h 143-782, v 35-514.

module vga_tile_renderer #(
    parameter int TILE_LOG2 = 4,
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int CW        = 2,
    parameter int X0        = 0,
    parameter int Y0        = 0,
    parameter int GAP       = 1,
    parameter int H_SYNC    = 96,
    parameter int H_START   = 143,
    parameter int H_ACT     = 640,
    parameter int H_TOTAL   = 800,
    parameter int V_SYNC    = 2,
    parameter int V_START   = 35,
    parameter int V_ACT     = 480,
    parameter int V_TOTAL   = 525
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      pix_en,
    input  logic [ROWS*COLS*CW-1:0]   tiles,
    input  logic                      pal_we,
    input  logic [CW-1:0]             pal_addr,
    input  logic [11:0]               pal_data,
    output logic [3:0]                r,
    output logic [3:0]                g,
    output logic [3:0]                b,
    output logic                      hs,
    output logic                      vs,
    output logic                      frame_start
);

    localparam int          HW     = $clog2(H_TOTAL);
    localparam int          VW     = $clog2(V_TOTAL);
    localparam int unsigned NPAL   = 1 << CW;
    localparam int          NBITS  = ROWS * COLS * CW;
    localparam int          SNAP_V = V_START + V_ACT;

    logic [HW-1:0]    r_h;
    logic [VW-1:0]    r_v;
    logic [NBITS-1:0] r_snap;
    logic [11:0]      r_pal [NPAL];

    logic             r_s1_black;
    logic [CW-1:0]    r_s1_idx;
    logic             r_s1_hs;
    logic             r_s1_vs;

    logic [11:0]      r_col;
    logic             r_hs;
    logic             r_vs;
    logic             r_fs;

    logic signed [31:0]   w_h;
    logic signed [31:0]   w_v;
    logic signed [31:0]   w_ox;
    logic signed [31:0]   w_oy;
    logic signed [31:0]   w_n;
    logic                 w_act;
    logic                 w_in;
    logic [CW-1:0]        w_code;
    logic [TILE_LOG2-1:0] w_sx;
    logic [TILE_LOG2-1:0] w_sy;
    logic                 w_edge;
    logic                 w_black;
    logic [CW-1:0]        w_idx;
    logic                 w_hs_raw;
    logic                 w_vs_raw;
    logic                 w_h_last;
    logic                 w_v_last;
    logic                 w_snap_now;

    function automatic logic [11:0] pal_default(input int unsigned i);
        case (i)
            1:       return 12'hF00;
            2:       return 12'h0F0;
            3:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    assign w_h = 32'(r_h);
    assign w_v = 32'(r_v);

    always_comb begin
        w_h_last   = (w_h == H_TOTAL - 1);
        w_v_last   = (w_v == V_TOTAL - 1);
        w_snap_now = (w_h == 0) && (w_v == SNAP_V);
        w_hs_raw   = (w_h >= H_SYNC);
        w_vs_raw   = (w_v >= V_SYNC);
        w_act      = (w_h >= H_START) && (w_h < H_START + H_ACT) &&
                     (w_v >= V_START) && (w_v < V_START + V_ACT);
        w_ox       = w_h - H_START - X0;
        w_oy       = w_v - V_START - Y0;
        w_in       = (w_ox >= 0) && (w_ox < (COLS << TILE_LOG2)) &&
                     (w_oy >= 0) && (w_oy < (ROWS << TILE_LOG2));
        // Index is forced to 0 outside the grid so the snapshot select stays in range.
        w_n        = w_in ? ((w_oy >>> TILE_LOG2) * COLS + (w_ox >>> TILE_LOG2)) : '0;
        w_code     = CW'(r_snap >> (w_n * CW));
        w_sx       = w_ox[TILE_LOG2-1:0];
        w_sy       = w_oy[TILE_LOG2-1:0];
        w_edge     = (w_sx == '0) || (w_sx == '1) || (w_sy == '0) || (w_sy == '1);
        // Outline only on non-zero tiles; code 0 shows palette[0] edge to edge.
        w_black    = !w_act || ((GAP != 0) && w_in && (w_code != '0) && w_edge);
        w_idx      = w_in ? w_code : '0;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_h <= '0;
            r_v <= '0;
        end else if (pix_en) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Tile map is latched once per frame at vblank start so a frame never tears.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_snap <= '0;
        end else if (pix_en && w_snap_now) begin
            r_snap <= tiles;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < NPAL; i++) begin
                r_pal[i] <= pal_default(i);
            end
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_s1_black <= 1'b1;
            r_s1_idx   <= '0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_col      <= '0;
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
        end else if (pix_en) begin
            r_s1_black <= w_black;
            r_s1_idx   <= w_idx;
            r_s1_hs    <= w_hs_raw;
            r_s1_vs    <= w_vs_raw;
            // Reads the pre-write palette when a write hits the same index this clk.
            r_col      <= r_s1_black ? 12'h000 : r_pal[r_s1_idx];
            r_hs       <= r_s1_hs;
            r_vs       <= r_s1_vs;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_fs <= 1'b0;
        end else begin
            r_fs <= pix_en && w_h_last && w_v_last;
        end
    end

    assign r           = r_col[3:0];
    assign g           = r_col[7:4];
    assign b           = r_col[11:8];
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer. A scaled raster (80x48 frame, 16-pixel tiles,
// 3x2 grid offset by (3,2)) keeps whole frames short; a second instance with
// default parameters covers the full-size sync widths on the first lines.
module tb_vga_tile_renderer;

    localparam int T     = 16;
    localparam int COLS  = 3;
    localparam int ROWS  = 2;
    localparam int X0    = 3;
    localparam int Y0    = 2;
    localparam int HSY   = 8;
    localparam int HST   = 12;
    localparam int HA    = 64;
    localparam int HT    = 80;
    localparam int VSY   = 2;
    localparam int VST   = 4;
    localparam int VA    = 40;
    localparam int VT    = 48;
    localparam int FRAME = HT * VT;
    localparam int SNAPV = VST + VA;

    logic        clk = 1'b0;
    logic        clrn;
    logic        pix_en;
    logic [11:0] tiles;
    logic        pal_we;
    logic [1:0]  pal_addr;
    logic [11:0] pal_data;
    logic [3:0]  r, g, b;
    logic        hs, vs, frame_start;

    logic [2399:0] tiles_d = '0;
    logic [3:0]    r_d, g_d, b_d;
    logic          hs_d, vs_d, fs_d;

    always #5 clk = ~clk;

    vga_tile_renderer #(
        .TILE_LOG2(4), .COLS(COLS), .ROWS(ROWS), .CW(2), .X0(X0), .Y0(Y0), .GAP(1),
        .H_SYNC(HSY), .H_START(HST), .H_ACT(HA), .H_TOTAL(HT),
        .V_SYNC(VSY), .V_START(VST), .V_ACT(VA), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .clrn(clrn), .pix_en(pix_en), .tiles(tiles),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .frame_start(frame_start)
    );

    vga_tile_renderer dut_d (
        .clk(clk), .clrn(clrn), .pix_en(pix_en), .tiles(tiles_d),
        .pal_we(1'b0), .pal_addr(2'b00), .pal_data(12'h000),
        .r(r_d), .g(g_d), .b(b_d), .hs(hs_d), .vs(vs_d), .frame_start(fs_d)
    );

    // Reference model: raster position, per-frame tile snapshot, palette.
    int          mh = 0, mv = 0, ph = 0, pv = 0, oh = -1, ov = -1;
    int          m_en = 0, cyc = 0;
    logic [1:0]  msnap [ROWS*COLS];
    logic [11:0] mpal [4];
    logic [11:0] e_col = '0;
    logic        e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [13:0] expect_px(input int h, input int v);
        int x, y, sx, sy;
        logic [1:0]  code;
        logic [11:0] col;
        x = h - HST - X0;
        y = v - VST - Y0;
        if (h < HST || h >= HST + HA || v < VST || v >= VST + VA) col = 12'h000;
        else if (x < 0 || x >= COLS * T || y < 0 || y >= ROWS * T) col = mpal[0];
        else begin
            code = msnap[(y / T) * COLS + x / T];
            sx = x % T;
            sy = y % T;
            if (code != 2'd0 && (sx == 0 || sx == T - 1 || sy == 0 || sy == T - 1)) col = 12'h000;
            else col = mpal[code];
        end
        return {h >= HSY, v >= VSY, col};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!clrn) begin
            mh = 0; mv = 0; m_en = 0; oh = -1; ov = -1;
            e_col = '0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0;
            for (int i = 0; i < ROWS * COLS; i++) msnap[i] = 2'd0;
            mpal[0] = 12'h000; mpal[1] = 12'hF00; mpal[2] = 12'h0F0; mpal[3] = 12'h00F;
        end else begin
            e_fs = 1'b0;
            if (pix_en) begin
                if (m_en >= 1) begin
                    {e_hs, e_vs, e_col} = expect_px(ph, pv);
                    oh = ph; ov = pv;
                end
                ph = mh; pv = mv;
                e_fs = (mh == HT - 1 && mv == VT - 1);
                if (mh == 0 && mv == SNAPV)
                    for (int i = 0; i < ROWS * COLS; i++) msnap[i] = tiles[2*i +: 2];
                mh = (mh + 1) % HT;
                if (mh == 0) mv = (mv + 1) % VT;
                m_en++;
            end
            if (pal_we) mpal[pal_addr] = pal_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (m_en >= 2) begin
            n_cmp++;
            if ({hs, vs, b, g, r, frame_start} !== {e_hs, e_vs, e_col, e_fs}) begin
                n_bad++;
                $display("FAIL pipe t=%0t pix=(%0d,%0d) got hs=%b vs=%b bgr=%h fs=%b need hs=%b vs=%b bgr=%h fs=%b",
                         $time, oh, ov, hs, vs, {b, g, r}, frame_start, e_hs, e_vs, e_col, e_fs);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0h need %0h", name, got, want);
        end
    endtask

    task automatic check_px(input string name, input int gx, input int gy, input logic [11:0] want);
        int th, tv, k;
        logic hit;
        th = HST + X0 + gx;
        tv = VST + Y0 + gy;
        k = 0;
        hit = 1'b0;
        while (!hit && k < 2 * FRAME) begin
            tick();
            k++;
            hit = (m_en >= 2 && oh == th && ov == tv);
        end
        if (!hit) check({name, "_timeout"}, 0, 1);
        else check(name, int'({b, g, r}), int'(want));
    endtask

    task automatic wait_fs(output int at);
        int k;
        k = 0;
        at = -1;
        while (at < 0 && k < 5 * FRAME) begin
            tick();
            k++;
            if (frame_start === 1'b1) at = cyc;
        end
        if (at < 0) check("frame_start_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int hh, input int vv);
        int k;
        k = 0;
        while (!(mh == hh && mv == vv) && k < 2 * FRAME) begin
            tick();
            k++;
        end
        if (k >= 2 * FRAME) check("wait_pos_timeout", 0, 1);
    endtask

    initial begin
        int hlo, vlo, dbad, t1, t2, t3, rel;
        clrn = 1'b0; pix_en = 1'b1; tiles = 12'h939;
        pal_we = 1'b0; pal_addr = 2'd0; pal_data = 12'h000;

        repeat (3) tick();
        check("reset_out", int'({r, g, b, hs, vs, frame_start}), 0);
        clrn = 1'b1;

        hlo = 0; vlo = 0; dbad = 0;
        for (int i = 0; i < 1700; i++) begin
            tick();
            if (m_en >= 2 && m_en <= 801 && !hs_d) hlo++;
            if (m_en >= 2 && m_en <= 1602 && !vs_d) vlo++;
            if (m_en >= 2 && ({r_d, g_d, b_d} != 12'h000 || fs_d)) dbad++;
        end
        check("def_hs_low", hlo, 96);
        check("def_vs_low", vlo, 1600);
        check("def_black", dbad, 0);

        wait_fs(t1);
        check_px("px00_edge", 0, 0, 12'h000);
        check_px("px11", 1, 1, 12'hF00);
        check_px("px15_3_edge", 15, 3, 12'h000);
        wait_pos(0, 20);
        tiles = 12'hFFF;
        check_px("no_tear", 20, 22, 12'hF00);

        wait_fs(t2);
        check_px("new_tiles_t0", 5, 5, 12'h00F);
        check_px("new_tiles_t4", 20, 22, 12'h00F);
        tiles = 12'h939;

        wait_fs(t3);
        check("fs_period", t3 - t2, FRAME);
        wait_pos(0, 10);
        pal_we = 1'b1; pal_addr = 2'd1; pal_data = 12'h5FF;
        tick();
        pal_addr = 2'd0; pal_data = 12'h321;
        tick();
        pal_we = 1'b0;
        check_px("pal0_code0", 5, 22, 12'h321);
        check_px("pal1_write", 20, 22, 12'h5FF);
        check_px("outside_pal0", 55, 22, 12'h321);

        hlo = 0; vlo = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (!hs) hlo++;
            if (!vs) vlo++;
        end
        check("hs_low_frame", hlo, HSY * VT);
        check("vs_low_frame", vlo, VSY * HT);

        for (int i = 0; i < 16000; i++) begin
            pix_en = (i % 4 == 0);
            if (i == 101) begin pal_we = 1'b1; pal_addr = 2'd2; pal_data = 12'h0A0; end
            if (i == 102) pal_we = 1'b0;
            tick();
        end
        pix_en = 1'b1;

        wait_pos(40, 30);
        clrn = 1'b0;
        repeat (3) tick();
        check("reset_mid", int'({r, g, b, hs, vs, frame_start}), 0);
        clrn = 1'b1;
        rel = cyc;
        wait_fs(t1);
        check("fs_after_reset", t1 - rel, FRAME);
        check_px("pal_restored1", 5, 5, 12'hF00);
        check_px("pal_restored2", 20, 5, 12'h0F0);
        check_px("pal_restored0", 55, 5, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
